// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - multi-cycle adder processing DIGIT bits per clock with carry-out and overflow
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] opa, opb, psum, psum_shift;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] dsum;
    logic             c_msb, c_out, last;

    // Ripple across the current digit; c_msb is the carry into the digit's top bit,
    // which on the final digit is the carry into bit WIDTH-1.
    always_comb begin
        logic c;
        c     = carry;
        dsum  = '0;
        c_msb = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) c_msb = c;
            dsum[i] = opa[i] ^ opb[i] ^ c;
            c       = (opa[i] & opb[i]) | (c & (opa[i] ^ opb[i]));
        end
        c_out = c;
    end

    assign psum_shift = (psum >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
    assign last       = (cnt == CW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            psum  <= '0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b;
                        carry <= cin;
                        psum  <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    opa   <= opa >> DIGIT;
                    opb   <= opb >> DIGIT;
                    carry <= c_out;
                    psum  <= psum_shift;
                    cnt   <= cnt + 1'b1;
                    // Visible results only move on completion.
                    if (last) begin
                        sum  <= psum_shift;
                        cout <= c_out;
                        ovf  <= c_msb ^ c_out;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized self-checking bench for serial_adder
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // 8-bit, one bit per clock
    logic       start = 1'b0, cin = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       busy, done, cout, ovf;
    logic [7:0] sum;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    // 8-bit, four bits per clock
    logic       start4 = 1'b0, c4 = 1'b0;
    logic [7:0] a4 = '0, b4 = '0;
    logic       busy4, done4, cout4, ovf4;
    logic [7:0] sum4;

    serial_adder #(.WIDTH(8), .DIGIT(4)) dut84 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(c4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    // 16-bit digit sweep
    localparam int DG[4] = '{1, 2, 4, 16};
    logic        start16 = 1'b0, c16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16[4], done16[4], cout16[4], ovf16[4];
    logic [15:0] sum16[4];

    for (genvar g = 0; g < 4; g++) begin : g16
        serial_adder #(.WIDTH(16), .DIGIT(DG[g])) u (
            .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(c16),
            .busy(busy16[g]), .done(done16[g]), .sum(sum16[g]), .cout(cout16[g]), .ovf(ovf16[g])
        );
    end

    // {ovf, cout, sum} from plain integer arithmetic
    function automatic logic [9:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
        int   s;
        logic ov;
        s  = int'(x) + int'(y) + int'(c);
        ov = (x[7] == y[7]) && (s[7] != x[7]);
        return {ov, s[8], s[7:0]};
    endfunction

    function automatic logic [17:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic c);
        int   s;
        logic ov;
        s  = int'(x) + int'(y) + int'(c);
        ov = (x[15] == y[15]) && (s[15] != x[15]);
        return {ov, s[16], s[15:0]};
    endfunction

    // Drive a request from a negedge; returns at the negedge after the accepting edge.
    task automatic go(input logic [7:0] x, input logic [7:0] y, input logic c);
        a = x; b = y; cin = c; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit held, output bit overlap);
        logic [7:0] s0;
        s0 = sum; held = 1'b1; overlap = 1'b0; lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); @(negedge clk);
            if (busy && done) overlap = 1'b1;
            if (done) begin lat = k; break; end
            if (sum !== s0) held = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, sum, cout, ovf} !== 12'h000) begin
            fails++;
            $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0", busy, done, sum, cout, ovf);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int lat; bit held, ovl;
        go(8'h0F, 8'h01, 1'b0);
        checks++;
        if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b required 1", busy); end
        wait_done(lat, held, ovl);
        checks++;
        if (lat != 8) begin fails++; $display("FAIL basic_latency: got %0d required 8", lat); end
        checks++;
        if (!held) begin fails++; $display("FAIL basic_sum_hold: sum changed before done, required 00"); end
        checks++;
        if ({ovf, cout, sum} !== 10'h010) begin
            fails++; $display("FAIL basic_result: got ovf=%b cout=%b sum=%h required 0 0 10", ovf, cout, sum);
        end
        checks++;
        if (ovl) begin fails++; $display("FAIL basic_overlap: busy and done both high"); end
    endtask

    task automatic test_flags;
        logic [7:0] ta[3] = '{8'hFF, 8'h7F, 8'h80};
        logic [7:0] tb[3] = '{8'h00, 8'h01, 8'h80};
        logic       tc[3] = '{1'b1, 1'b0, 1'b0};
        logic [9:0] exp;
        int lat; bit held, ovl;
        for (int i = 0; i < 23; i++) begin
            logic [7:0] x, y; logic c;
            if (i < 3) begin x = ta[i]; y = tb[i]; c = tc[i]; end
            else begin x = 8'($urandom); y = 8'($urandom); c = 1'($urandom); end
            exp = ref8(x, y, c);
            go(x, y, c);
            wait_done(lat, held, ovl);
            checks++;
            if (lat != 8 || {ovf, cout, sum} !== exp) begin
                fails++;
                $display("FAIL flags_%0d: %h+%h+%b got lat=%0d ovf=%b cout=%b sum=%h required lat=8 %b %b %h",
                         i, x, y, c, lat, ovf, cout, sum, exp[9], exp[8], exp[7:0]);
            end
        end
    endtask

    task automatic test_busy_ignore;
        int lat, extra; bit held, ovl;
        logic [9:0] exp;
        go(8'h12, 8'h34, 1'b1);
        repeat (2) begin @(posedge clk); @(negedge clk); end
        a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        wait_done(lat, held, ovl);
        checks++;
        if (lat != 5 || {ovf, cout, sum} !== 10'h047) begin
            fails++; $display("FAIL ignore_start: lat=%0d sum=%h cout=%b ovf=%b required lat=5 sum=47 0 0", lat, sum, cout, ovf);
        end
        // Re-issue in the done cycle
        exp = ref8(8'hC3, 8'h5A, 1'b0);
        go(8'hC3, 8'h5A, 1'b0);
        wait_done(lat, held, ovl);
        checks++;
        if (lat != 8 || {ovf, cout, sum} !== exp) begin
            fails++; $display("FAIL back_to_back: lat=%0d result=%h required lat=8 result=%h", lat, {ovf, cout, sum}, exp);
        end
        extra = 0;
        repeat (10) begin @(posedge clk); @(negedge clk); if (done) extra++; end
        checks++;
        if (extra != 0) begin fails++; $display("FAIL spurious_done: got %0d extra pulses required 0", extra); end
    endtask

    task automatic test_reset_mid;
        int lat, extra; bit held, ovl;
        go(8'hF0, 8'h20, 1'b0);
        wait_done(lat, held, ovl);
        checks++;
        if ({cout, sum} !== 9'h110) begin fails++; $display("FAIL pre_reset_result: got %h required 110", {cout, sum}); end
        go(8'h01, 8'h02, 1'b0);
        repeat (3) begin @(posedge clk); @(negedge clk); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, sum, cout, ovf} !== 12'h000) begin
            fails++; $display("FAIL async_reset: busy=%b done=%b sum=%h cout=%b ovf=%b required all 0", busy, done, sum, cout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (12) begin @(posedge clk); @(negedge clk); if (done || busy) extra++; end
        checks++;
        if (extra != 0) begin fails++; $display("FAIL post_reset_idle: got %0d busy/done cycles required 0", extra); end
        go(8'h3C, 8'h44, 1'b1);
        wait_done(lat, held, ovl);
        checks++;
        if (lat != 8 || {ovf, cout, sum} !== 10'h281) begin
            fails++; $display("FAIL post_reset_op: lat=%0d result=%h required lat=8 result=281", lat, {ovf, cout, sum});
        end
    endtask

    task automatic test_digit_sweep;
        int lat[4];
        logic [17:0] exp;
        for (int it = 0; it < 400; it++) begin
            a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
            if (it == 0) begin a16 = 16'hFFFF; b16 = 16'h0000; c16 = 1'b1; end
            if (it == 1) begin a16 = 16'h7FFF; b16 = 16'h0001; c16 = 1'b0; end
            exp = ref16(a16, b16, c16);
            start16 = 1'b1;
            @(posedge clk); @(negedge clk);
            start16 = 1'b0;
            for (int g = 0; g < 4; g++) lat[g] = -1;
            for (int k = 1; k <= 20; k++) begin
                @(posedge clk); @(negedge clk);
                for (int g = 0; g < 4; g++) begin
                    if (done16[g]) begin
                        if (lat[g] < 0) lat[g] = k;
                        checks++;
                        if ({ovf16[g], cout16[g], sum16[g]} !== exp) begin
                            fails++;
                            $display("FAIL sweep_d%0d: %h+%h+%b got %h required %h", DG[g], a16, b16, c16,
                                     {ovf16[g], cout16[g], sum16[g]}, exp);
                        end
                    end
                end
            end
            for (int g = 0; g < 4; g++) begin
                checks++;
                if (lat[g] != 16 / DG[g]) begin
                    fails++; $display("FAIL sweep_latency_d%0d: got %0d required %0d", DG[g], lat[g], 16 / DG[g]);
                end
            end
        end
    endtask

    task automatic test_continuous;
        logic [7:0] ea, eb; logic ec;
        logic [9:0] exp;
        ea = '0; eb = '0; ec = 1'b0;
        start4 = 1'b1;
        for (int t = 0; t < 60; t++) begin
            a4 = 8'($urandom); b4 = 8'($urandom); c4 = 1'($urandom);
            if (t % 3 == 0) begin ea = a4; eb = b4; ec = c4; end
            @(posedge clk); @(negedge clk);
            checks++;
            if (done4 !== (t % 3 == 2) || busy4 !== (t % 3 != 2)) begin
                fails++; $display("FAIL cont_handshake_t%0d: done=%b busy=%b required %b %b", t, done4, busy4, t % 3 == 2, t % 3 != 2);
            end
            if (t % 3 == 2) begin
                exp = ref8(ea, eb, ec);
                checks++;
                if ({ovf4, cout4, sum4} !== exp) begin
                    fails++; $display("FAIL cont_result_t%0d: got %h required %h", t, {ovf4, cout4, sum4}, exp);
                end
            end
        end
        start4 = 1'b0;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_flags;
        test_busy_ignore;
        test_reset_mid;
        test_digit_sweep;
        test_continuous;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
